seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the six-digit common board display. It shares one 8-bit segment bus among NUM_DIG digit positions by cycling a one-hot digit select. It inserts a blanking gap at each digit change to suppress ghosting. Digit values are written into a shadow bank and committed to the displayed bank only at a frame boundary, so the display never shows a half-updated frame.

## Interface
- NUM_DIG, 6: digit positions; legal 2..8.
- SCAN_CYCLES, 250: clk cycles each digit is scheduled (dwell).
- BLANK_CYCLES, 8: leading cycles of each dwell with the display dark; must be < SCAN_CYCLES.
- clk  in  1  system clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  shadow write request.
- wr_ready  out  1  high when shadow writes and commit are accepted (= !commit_pending).
- wr_addr  in  3  digit index.
- wr_data  in  4  hex value for the digit.
- wr_dp  in  1  decimal point for the digit.
- wr_on  in  1  digit enable; 0 keeps the digit dark.
- commit  in  1  pulse; request shadow→active copy at the next frame end.
- commit_done  out  1  one-cycle pulse when the copy happens.
- frame_done  out  1  one-cycle pulse at the end of every full scan.
- sel  out  NUM_DIG  one-hot digit select, active-high.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.

## Operation
- Dwell counter cnt runs 0..SCAN_CYCLES-1. Digit index idx advances when cnt==SCAN_CYCLES-1. idx wraps from NUM_DIG-1 to 0.
- Frame end (FE) is the cycle with idx==NUM_DIG-1 and cnt==SCAN_CYCLES-1.
- Per-digit state, banked shadow and active: val[3:0], dp, on.
- Write handshake: the write is accepted when wr_en && wr_ready && wr_addr<NUM_DIG.
  - An accepted write updates the shadow entry wr_addr on the next edge.
  - wr_addr>=NUM_DIG: write dropped.
  - wr_en while !wr_ready: write dropped; shadow unchanged.
- Commit FSM has two states: IDLE, PENDING.
  - IDLE→PENDING on commit.
  - In PENDING, commit and wr_en are ignored.
  - PENDING→IDLE at FE: all shadow entries copy to active and commit_done pulses in the same cycle as frame_done.
- Commit with PENDING entered exactly on an FE cycle (commit while IDLE at FE): no copy at that FE; the copy happens at the following FE.
- wr_en and commit in the same IDLE cycle: the write is accepted and is included in the commit.
- Display rule, registered from (idx, cnt) of the previous cycle:
  - Dark when cnt<BLANK_CYCLES or active on[idx]==0: sel=0, seg=8'h00.
  - Otherwise: sel=1<<idx, seg={dp[idx], decode(val[idx])}.
- Decode map: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.

## Timing
- Reset values: cnt=0, idx=0, FSM=IDLE, shadow and active banks all zero (all digits off), sel=0, seg=8'h00, wr_ready=1, commit_done=0, frame_done=0.
- sel/seg lag (idx, cnt) by exactly one cycle.
- The first lit cycle after reset is cycle BLANK_CYCLES+1, and only if active on[0]=1.
- frame_done and commit_done are combinational-free registered pulses, asserted on the edge after FE.
- wr_ready falls the cycle after commit is sampled. It rises the cycle after FE.
- Commit latency: 1..NUM_DIG*SCAN_CYCLES cycles, depending on frame phase.
- The active bank never changes except at FE, so all digits in one frame come from one consistent bank.
- rst mid-frame or mid-PENDING returns everything to reset values on the next edge. A pending commit is discarded.

## Structure
- Package seg_pkg holds:
  - the segment bit-order constants
  - the 16-entry hex-to-segment table
  - the localparam width helpers (clog2 of SCAN_CYCLES, NUM_DIG)
- Sub-module seg_hex_decode: pure combinational 4→7 decode from the table; it is instanced once, on the muxed active value.
- The top level holds the counters, the commit FSM, both banks and the output registers.

## Test plan
All scenarios use NUM_DIG=6, SCAN_CYCLES=8, BLANK_CYCLES=2.
- Reset then idle, no writes → sel=0, seg=00 for 200 cycles; frame_done pulses every 48 cycles.
- Write digits 0..5 = 1,2,3,4,5,6 all on, commit → after the next FE each dwell shows 2 dark cycles then sel=000001/seg=06, sel=000010/seg=5B, ..., sel=100000/seg=7D.
- Write digit 2 = 8 with dp=1, on=1 during a frame without commit → display unchanged. After commit+FE, digit 2 shows seg=FF.
- With PENDING set, drive wr_en with addr 0 data F → wr_ready=0, write dropped; after commit_done, digit 0 keeps its old value.
- Write wr_addr=7 → ignored; no bank changes.
- Assert rst for 1 cycle while PENDING at idx=3, cnt=5 → next cycle sel=0, seg=00, wr_ready=1; no commit_done at the following FE.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the segment scan controller: segment bit order,
// hex-to-segment table and counter width helper.
package seg_pkg;

    // Bit positions of the segments on the 8-bit bus {dp,g,f,e,d,c,b,a}.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Hex digit to {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Commit FSM states.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to 7-segment decoder driven from the shared table.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_val];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed digit scan controller with per-dwell blanking and a
// shadow/active digit bank that is swapped only at the end of a frame.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIG      = 6,
    parameter int SCAN_CYCLES  = 250,
    parameter int BLANK_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    output logic               wr_ready,
    input  logic [2:0]         wr_addr,
    input  logic [3:0]         wr_data,
    input  logic               wr_dp,
    input  logic               wr_on,
    input  logic               commit,
    output logic               commit_done,
    output logic               frame_done,
    output logic [NUM_DIG-1:0] sel,
    output logic [7:0]         seg
);

    localparam int CNT_W = width_of(SCAN_CYCLES);
    localparam int IDX_W = width_of(NUM_DIG);

    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               w_cnt_last;
    logic               w_idx_last;
    logic               w_fe;

    commit_state_t      r_state;
    commit_state_t      w_state_next;
    logic               w_copy;
    logic               w_wr_acc;
    logic [NUM_DIG-1:0] w_wr_hit;

    logic [3:0]         r_shd_val [NUM_DIG];
    logic               r_shd_dp  [NUM_DIG];
    logic               r_shd_on  [NUM_DIG];
    logic [3:0]         r_act_val [NUM_DIG];
    logic               r_act_dp  [NUM_DIG];
    logic               r_act_on  [NUM_DIG];

    logic [3:0]         w_act_val;
    logic [6:0]         w_seg7;
    logic               w_dark;

    logic [NUM_DIG-1:0] r_sel;
    logic [7:0]         r_seg;
    logic               r_frame_done;
    logic               r_commit_done;

    assign w_cnt_last = (r_cnt == CNT_W'(SCAN_CYCLES - 1));
    assign w_idx_last = (r_idx == IDX_W'(NUM_DIG - 1));
    assign w_fe       = w_cnt_last && w_idx_last;

    // Dwell counter and digit index; index steps on the last dwell cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Commit FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Commit FSM next state; a commit sampled on a frame end waits for the next one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (commit) w_state_next = ST_PENDING;
            ST_PENDING: if (w_fe)   w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Commit FSM outputs: write acceptance and the bank copy strobe.
    always_comb begin
        wr_ready = (r_state == ST_IDLE);
        w_copy   = (r_state == ST_PENDING) && w_fe;
    end

    assign w_wr_acc = wr_en && wr_ready && ({1'b0, wr_addr} < 4'(NUM_DIG));

    generate
        for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_hit
            assign w_wr_hit[gi] = w_wr_acc && (wr_addr == 3'(gi));
        end
    endgenerate

    // Shadow bank takes accepted writes; active bank loads from shadow at commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                r_shd_val[i] <= '0;
                r_shd_dp[i]  <= 1'b0;
                r_shd_on[i]  <= 1'b0;
                r_act_val[i] <= '0;
                r_act_dp[i]  <= 1'b0;
                r_act_on[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_DIG; i++) begin
                if (w_wr_hit[i]) begin
                    r_shd_val[i] <= wr_data;
                    r_shd_dp[i]  <= wr_dp;
                    r_shd_on[i]  <= wr_on;
                end
                if (w_copy) begin
                    r_act_val[i] <= r_shd_val[i];
                    r_act_dp[i]  <= r_shd_dp[i];
                    r_act_on[i]  <= r_shd_on[i];
                end
            end
        end
    end

    assign w_act_val = r_act_val[r_idx];
    assign w_dark    = (r_cnt < CNT_W'(BLANK_CYCLES)) || !r_act_on[r_idx];

    seg_hex_decode u_dec (
        .i_val (w_act_val),
        .o_seg (w_seg7)
    );

    // Output registers: display one cycle behind the scan position, plus pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel         <= '0;
            r_seg         <= '0;
            r_frame_done  <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            if (w_dark) begin
                r_sel <= '0;
                r_seg <= '0;
            end else begin
                r_sel         <= NUM_DIG'(1) << r_idx;
                r_seg[SEG_DP] <= r_act_dp[r_idx];
                r_seg[SEG_G:SEG_A] <= w_seg7;
            end
            r_frame_done  <= w_fe;
            r_commit_done <= w_copy;
        end
    end

    assign sel         = r_sel;
    assign seg         = r_seg;
    assign frame_done  = r_frame_done;
    assign commit_done = r_commit_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised and directed stimulus for seg_scan_ctrl, checked every cycle
// against a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int ND    = 6;
    localparam int SC    = 8;
    localparam int BL    = 2;
    localparam int FRAME = ND * SC;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_ready;
    logic [2:0]    wr_addr = '0;
    logic [3:0]    wr_data = '0;
    logic          wr_dp = 1'b0;
    logic          wr_on = 1'b0;
    logic          commit = 1'b0;
    logic          commit_done;
    logic          frame_done;
    logic [ND-1:0] sel;
    logic [7:0]    seg;

    int checks   = 0;
    int failures = 0;

    // Reference model state: position in frame counted from reset.
    int         t = 0;
    bit         pend = 0;
    logic [3:0] m_shd_val [ND];
    bit         m_shd_dp  [ND];
    bit         m_shd_on  [ND];
    logic [3:0] m_act_val [ND];
    bit         m_act_dp  [ND];
    bit         m_act_on  [ND];
    logic [6:0] ref_tbl   [16];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIG      (ND),
        .SCAN_CYCLES  (SC),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_on       (wr_on),
        .commit      (commit),
        .commit_done (commit_done),
        .frame_done  (frame_done),
        .sel         (sel),
        .seg         (seg)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h want=%0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        t    = 0;
        pend = 0;
        for (int i = 0; i < ND; i++) begin
            m_shd_val[i] = '0; m_shd_dp[i] = 0; m_shd_on[i] = 0;
            m_act_val[i] = '0; m_act_dp[i] = 0; m_act_on[i] = 0;
        end
    endtask

    // One clock: drive inputs, predict outputs after the edge, check them.
    task automatic cycle(input bit r, input bit we, input logic [2:0] a,
                         input logic [3:0] d, input bit dp, input bit on, input bit cm);
        int         pos, idx, cnt;
        bit         fe, dark;
        logic [5:0] e_sel;
        logic [7:0] e_seg;
        bit         e_fd, e_cd;
        rst = r; wr_en = we; wr_addr = a; wr_data = d; wr_dp = dp; wr_on = on; commit = cm;
        if (r) begin
            model_reset();
            e_sel = '0; e_seg = '0; e_fd = 0; e_cd = 0;
        end else begin
            pos  = t % FRAME;
            idx  = pos / SC;
            cnt  = pos % SC;
            fe   = (pos == FRAME - 1);
            dark = (cnt < BL) || !m_act_on[idx];
            e_sel = dark ? 6'd0 : (6'd1 << idx);
            e_seg = dark ? 8'd0 : {m_act_dp[idx], ref_tbl[m_act_val[idx]]};
            e_fd  = fe;
            e_cd  = pend && fe;
            if (!pend && we && a < ND) begin
                m_shd_val[a] = d; m_shd_dp[a] = dp; m_shd_on[a] = on;
            end
            if (pend && fe) begin
                for (int i = 0; i < ND; i++) begin
                    m_act_val[i] = m_shd_val[i];
                    m_act_dp[i]  = m_shd_dp[i];
                    m_act_on[i]  = m_shd_on[i];
                end
                pend = 0;
            end else if (!pend && cm) begin
                pend = 1;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check_eq("sel", 32'(sel), 32'(e_sel));
        check_eq("seg", 32'(seg), 32'(e_seg));
        check_eq("frame_done", 32'(frame_done), 32'(e_fd));
        check_eq("commit_done", 32'(commit_done), 32'(e_cd));
        check_eq("wr_ready", 32'(wr_ready), 32'(!pend));
        if (e_cd) $display("commit_done at t=%0d", $time);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 3'd0, 4'd0, 0, 0, 0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d, input bit dp, input bit on);
        cycle(0, 1, a, d, dp, on, 0);
        $display("write addr=%0d data=%0h dp=%0d on=%0d", a, d, dp, on);
    endtask

    initial begin
        ref_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();

        // Reset, then idle dark display with periodic frame_done.
        repeat (3) cycle(1, 0, 3'd0, 4'd0, 0, 0, 0);
        idle(200);

        // Digits 0..5 = 1..6, all on, committed.
        for (int i = 0; i < ND; i++) wr(3'(i), 4'(i + 1), 0, 1);
        cycle(0, 0, 3'd0, 4'd0, 0, 0, 1);
        idle(2 * FRAME + 5);

        // Digit 2 = 8 with dp: invisible until committed.
        wr(3'd2, 4'd8, 1, 1);
        idle(FRAME + 3);
        cycle(0, 0, 3'd0, 4'd0, 0, 0, 1);
        idle(2 * FRAME);

        // Writes while pending are dropped.
        cycle(0, 0, 3'd0, 4'd0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(0, 1, 3'd0, 4'hF, 1, 1, 0);
        idle(2 * FRAME);

        // Out-of-range address is ignored; write+commit in one cycle.
        wr(3'd7, 4'hA, 1, 1);
        cycle(0, 1, 3'd5, 4'hC, 0, 1, 1);
        idle(2 * FRAME);

        // Commit sampled exactly on a frame end copies only at the next one.
        for (int k = 0; k < 2 * FRAME && !((t % FRAME == FRAME - 1) && !pend); k++) idle(1);
        check_eq("reach_fe", 32'((t % FRAME == FRAME - 1) && !pend), 32'd1);
        wr(3'd1, 4'hE, 0, 1);
        for (int k = 0; k < 2 * FRAME && !((t % FRAME == FRAME - 1) && !pend); k++) idle(1);
        cycle(0, 0, 3'd0, 4'd0, 0, 0, 1);
        idle(2 * FRAME + 2);

        // Reset while pending at idx=3, cnt=5 discards the commit.
        wr(3'd3, 4'h9, 1, 1);
        cycle(0, 0, 3'd0, 4'd0, 0, 0, 1);
        for (int k = 0; k < 2 * FRAME && !(pend && (t % FRAME == 3 * SC + 5)); k++) idle(1);
        check_eq("reach_mid", 32'(pend && (t % FRAME == 3 * SC + 5)), 32'd1);
        cycle(1, 0, 3'd0, 4'd0, 0, 0, 0);
        idle(2 * FRAME);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
